// File: rtl/pkt_link_pkg.sv
// Shared constants and types for the 64-bit sync-framed serial link.
// The transmitter and the receiver-side checker both use this package.
package pkt_link_pkg;

    localparam int FRAME_W   = 64;
    localparam int PAYLOAD_W = 44;

    localparam int SYNC1_HI = 62;
    localparam int SYNC1_W  = 5;
    localparam int SYNC2_HI = 36;
    localparam int SYNC2_W  = 5;
    localparam int SYNC3_HI = 8;
    localparam int SYNC3_W  = 9;

    // Field positions inside the frame and inside the payload
    localparam int FIELD_A_HI = 57;
    localparam int FIELD_A_LO = 37;
    localparam int FIELD_B_HI = 31;
    localparam int FIELD_B_LO = 9;
    localparam int PAY_A_HI   = 43;
    localparam int PAY_A_LO   = 23;
    localparam int PAY_B_HI   = 22;
    localparam int PAY_B_LO   = 0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

endpackage

// File: rtl/pkt_frame_builder.sv
// Combinational frame assembly: guard bit, three all-ones sync runs and the two payload fields.
module pkt_frame_builder
    import pkt_link_pkg::*;
(
    input  logic [PAYLOAD_W-1:0] payload,
    output logic [FRAME_W-1:0]   frame
);

    // The guard bit at the top stays zero from the default.
    always_comb begin
        frame = '0;
        frame[SYNC1_HI -: SYNC1_W]     = '1;
        frame[FIELD_A_HI:FIELD_A_LO]   = payload[PAY_A_HI:PAY_A_LO];
        frame[SYNC2_HI -: SYNC2_W]     = '1;
        frame[FIELD_B_HI:FIELD_B_LO]   = payload[PAY_B_HI:PAY_B_LO];
        frame[SYNC3_HI -: SYNC3_W]     = '1;
    end

endmodule

// File: rtl/pkt_serializer.sv
// Transmit end of the sync-framed serial link: one-deep hold register, frame
// shifter MSB-first at the en strobe rate, and an idle-zero gap between frames.
module pkt_serializer
    import pkt_link_pkg::*;
#(
    parameter int GAP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 dout,
    output logic                 busy,
    output logic                 pkt_sent
);

    localparam logic [3:0] GAP_INIT = 4'(GAP_BITS - 1);
    localparam logic [5:0] BIT_LAST = 6'(FRAME_W - 1);

    state_e                 state;
    logic                   hold_full;
    logic [PAYLOAD_W-1:0]   hold_data;
    logic [FRAME_W-1:0]     frame;
    logic [FRAME_W-1:0]     shreg;
    logic [5:0]             bitcnt;
    logic [3:0]             gapcnt;
    logic                   take;
    logic                   consume;

    pkt_frame_builder u_builder (
        .payload (hold_data),
        .frame   (frame)
    );

    assign take = load_valid && load_ready;

    // consume marks every en edge that moves the held payload into the shifter.
    always_comb begin
        consume = 1'b0;
        if (en && hold_full) begin
            case (state)
                IDLE:    consume = 1'b1;
                SEND:    consume = (bitcnt == '0) && (GAP_BITS == 0);
                GAP:     consume = (gapcnt == '0);
                default: consume = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full  <= 1'b0;
            hold_data  <= '0;
            load_ready <= 1'b1;
        end else if (take) begin
            hold_full  <= 1'b1;
            hold_data  <= payload;
            load_ready <= 1'b0;
        end else if (consume) begin
            hold_full  <= 1'b0;
            load_ready <= 1'b1;
        end
    end

    hold_collision: assert property (@(posedge clk) disable iff (!rst) !(take && consume));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            gapcnt   <= '0;
            dout     <= 1'b0;
            busy     <= 1'b0;
            pkt_sent <= 1'b0;
        end else begin
            pkt_sent <= 1'b0;
            if (en) begin
                if (state == SEND && bitcnt == '0) begin
                    pkt_sent <= 1'b1;
                end
                if (consume) begin
                    shreg  <= frame;
                    dout   <= frame[FRAME_W-1];
                    bitcnt <= BIT_LAST;
                    state  <= SEND;
                    busy   <= 1'b1;
                end else begin
                    case (state)
                        SEND: begin
                            if (bitcnt != '0) begin
                                shreg  <= shreg << 1;
                                dout   <= shreg[FRAME_W-2];
                                bitcnt <= bitcnt - 6'd1;
                            end else if (GAP_BITS > 0) begin
                                dout   <= 1'b0;
                                gapcnt <= GAP_INIT;
                                state  <= GAP;
                            end else begin
                                dout   <= 1'b0;
                                state  <= IDLE;
                                busy   <= 1'b0;
                            end
                        end
                        GAP: begin
                            if (gapcnt != '0) begin
                                gapcnt <= gapcnt - 4'd1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/pkt_serializer.md
# pkt_serializer

- Transmit end of the 64-bit sync-framed serial link.
- Accepts 44-bit payloads over a valid/ready handshake and builds a frame with three all-ones sync fields.
- Shifts the frame out MSB-first, one bit per `en` strobe.
- Sits ahead of the serial line whose far end is `Shift_Buffer`. After 64 strobes, the receiver's `dout` equals the transmitted frame and `pkt_rec` asserts.

## Interface
- `GAP_BITS`, default 4: idle-zero bit periods inserted after each frame. Legal range 0–15.
- `clk  in  1`: single clock.
- `rst  in  1`: asynchronous, active-low reset.
- `en  in  1`: bit-rate strobe. Every state change, shift and bit advance happens only on cycles with `en`=1.
- `payload  in  44`: frame data. `payload[43:23]` is field A; `payload[22:0]` is field B.
- `load_valid  in  1`: payload offered.
- `load_ready  out  1`: hold register empty.
- `dout  out  1`: serial line, registered.
- `busy  out  1`: high while in the SEND or GAP state.
- `pkt_sent  out  1`: one-cycle pulse when a frame's last bit period ends.

## Operation
- Frame layout, bit 63 transmitted first:
  - [63] = 0 (guard bit)
  - [62:58] = 5'b11111 (sync1)
  - [57:37] = field A
  - [36:32] = 5'b11111 (sync2)
  - [31:9] = field B
  - [8:0] = 9'h1FF (sync3)
- Hold register (1 deep):
  - A payload is captured when `load_valid && load_ready`. `en` is not required.
  - `load_ready` = !hold_full, registered. There is no same-cycle bypass.
- FSM states are IDLE, SEND and GAP.
- IDLE:
  - `dout`=0.
  - On `en` with hold_full: load the shift register with the built frame, drive `dout`=frame[63], set bitcnt=63, clear hold_full, go to SEND.
- SEND:
  - On `en` with bitcnt>0: shift left, `dout`=next bit, decrement bitcnt.
  - On `en` with bitcnt==0: pulse `pkt_sent`, then:
    - if GAP_BITS>0: `dout`=0, gapcnt=GAP_BITS−1, go to GAP;
    - if GAP_BITS==0 and hold_full: load the next frame immediately (back-to-back, no idle bit);
    - otherwise: `dout`=0, go to IDLE.
- GAP:
  - `dout`=0.
  - On `en` with gapcnt>0: decrement gapcnt.
  - On `en` with gapcnt==0:
    - if hold_full: load the next frame, as in IDLE;
    - otherwise: go to IDLE.
- While `en`=0, state, counters and `dout` hold their values.
- A payload can be accepted during SEND or GAP. The hold register refills while a frame is in flight.
- The idle line level is 0, so the receiver never sees a false sync run between frames.

## Timing
- Reset values:
  - `dout`=0, `busy`=0, `pkt_sent`=0, `load_ready`=1.
  - State IDLE, hold_full=0, shift register=0, bitcnt=0, gapcnt=0.
- Reset mid-frame aborts the frame immediately and discards the held payload.
- Latency from acceptance to first bit: frame[63] appears on the first `en` cycle strictly after the acceptance cycle, provided the block is in IDLE.
- Frame duration: exactly 64 `en` periods. `pkt_sent` is high during the cycle following the `en` edge that ends bit 0.
- Frame-to-frame spacing: 64+GAP_BITS `en` periods when the hold register is kept full.
- If acceptance and consumption fall in the same cycle: consumption clears hold_full, the acceptance sets it, and set wins. `load_ready` was already 0 in that cycle, so this is only reachable if the hold logic is wrong. Assert on it.
- `load_valid` held while `load_ready`=0: `payload` must stay stable; no capture occurs.

## Structure
- Package `pkt_link_pkg` holds:
  - FRAME_W=64 and PAYLOAD_W=44;
  - the sync field positions and values (SYNC1_HI=62, SYNC2_HI=36, SYNC3_HI=8);
  - the field A/B bounds;
  - the state enum {IDLE, SEND, GAP}.
- Sub-module `pkt_frame_builder`: combinational, payload[43:0] → frame[63:0]. It is shared with the receiver-side checker.
- Top-level: hold register, FSM, 6-bit bitcnt, 4-bit gapcnt, 64-bit shift register.

## Test plan
- Reset, then payload=44'h0 with `en` every 10 clks. Captured `dout` stream = 64'h7C00_001F_0000_01FF. A `Shift_Buffer` loopback shows `pkt_rec`=1 after bit 0.
- payload=44'hFFF_FFFF_FFFF gives 64'h7FFF_FFFF_FFFF_FFFF. `pkt_sent` pulses once, exactly 64 `en` periods after the first bit.
- Two payloads back-to-back with GAP_BITS=4:
  - second accepted during the first frame; `load_ready` drops and then reasserts at the start of frame 2;
  - exactly 4 zero bits between frames.
- GAP_BITS=0 with hold pre-filled: frames abut with no idle bit, and `busy` never drops.
- `en` held low for 100 clks mid-frame: `dout` and bitcnt are frozen, and the resumed stream is identical to the uninterrupted one.
- Assert `rst` low at bit 30 of a frame: `dout`=0 and `load_ready`=1 asynchronously. A new payload afterwards transmits cleanly from bit 63.
